// File: rtl/stats_pkg.sv
// Shared types and constants for the run-statistics sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stats_pkg;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_FRAC_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DIV  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Order in which the report words leave the dump port
  localparam logic [2:0] IDX_CYCLES = 3'd0;
  localparam logic [2:0] IDX_INSTR  = 3'd1;
  localparam logic [2:0] IDX_STALL  = 3'd2;
  localparam logic [2:0] IDX_BRANCH = 3'd3;
  localparam logic [2:0] IDX_IPC    = 3'd4;
  localparam int         NUM_BEATS  = 5;

endpackage

// File: rtl/stats_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Latency: valid rises NUM_W-1 cycles after the start edge; the first bit is resolved on the start edge itself.
// Backpressure: none; valid and quot hold until the next start.
module stats_divider #(
  parameter int NUM_W = 40,
  parameter int DEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             valid,
  output logic [NUM_W-1:0] quot
);

  localparam int CNT_BITS = $clog2(NUM_W + 1);

  logic [DEN_W-1:0]    rem_q, rem_d;
  logic [NUM_W-1:0]    q_q, q_d;
  logic [DEN_W-1:0]    den_q, den_d;
  logic                zero_q, zero_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // One restoring step, applied either to fresh operands (start) or to the running state
  logic [DEN_W-1:0] src_rem;
  logic [NUM_W-1:0] src_q;
  logic [DEN_W-1:0] src_den;
  logic [DEN_W:0]   shifted;
  logic             ge;
  logic [DEN_W-1:0] step_rem;
  logic [NUM_W-1:0] step_q;

  // Shift the next numerator bit into the remainder and subtract the divisor if it fits
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_q    = start ? num : q_q;
    src_den  = start ? den : den_q;
    shifted  = {src_rem, src_q[NUM_W-1]};
    ge       = (shifted >= {1'b0, src_den});
    step_rem = ge ? DEN_W'(shifted - {1'b0, src_den}) : shifted[DEN_W-1:0];
    step_q   = {src_q[NUM_W-2:0], ge};
  end

  // Sequencing: load on start, iterate while busy, flag the result after the last bit
  always_comb begin
    rem_d   = rem_q;
    q_d     = q_q;
    den_d   = den_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (start) begin
      rem_d   = step_rem;
      q_d     = step_q;
      den_d   = den;
      zero_d  = (den == '0);
      busy_d  = 1'b1;
      valid_d = 1'b0;
      cnt_d   = CNT_BITS'(NUM_W - 1);
    end else if (busy_q) begin
      rem_d = step_rem;
      q_d   = step_q;
      cnt_d = cnt_q - CNT_BITS'(1);
      if (cnt_q == CNT_BITS'(1)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      q_q     <= '0;
      den_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rem_q   <= rem_d;
      q_q     <= q_d;
      den_q   <= den_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // A zero divisor would yield all-ones from the restoring loop; report 0 instead
  assign quot  = zero_q ? '0 : q_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule

// File: rtl/stats_sequencer.sv
// Run-statistics controller: counts a run, divides out IPC, then dumps five words.
// Latency: dump_valid rises CNT_W+FRAC_W cycles after entering DIV; one beat per cycle with ready high.
// Backpressure: beat held stable while dump_valid && !dump_ready; valid never depends on ready combinationally.
module stats_sequencer
  import stats_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             inst_retire,
  input  logic             stall,
  input  logic             br_taken,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [2:0]       dump_idx,
  output logic [CNT_W-1:0] dump_data,
  output logic             busy,
  output logic             done
);

  localparam int Q_W = CNT_W + FRAC_W;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;
  logic [CNT_W-1:0] stl_q, stl_d;
  logic [CNT_W-1:0] brn_q, brn_d;
  logic [2:0]       idx_q, idx_d;

  logic             div_start;
  logic             div_busy;
  logic             div_valid;
  logic [Q_W-1:0]   div_quot;
  logic [CNT_W-1:0] ipc;

  // Next-state, saturating counters and divider launch
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    ins_d     = ins_q;
    stl_d     = stl_q;
    brn_d     = brn_q;
    idx_d     = idx_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cyc_d   = '0;
          ins_d   = '0;
          stl_d   = '0;
          brn_d   = '0;
          idx_d   = IDX_CYCLES;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
        if (inst_retire && ins_q != '1) ins_d = ins_q + CNT_W'(1);
        if (stall && stl_q != '1) stl_d = stl_q + CNT_W'(1);
        if (br_taken && brn_q != '1) brn_d = brn_q + CNT_W'(1);
        // Halt cycle is counted, so the divider takes the post-update values
        if (halt) begin
          div_start = 1'b1;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_valid && !div_busy) begin
          idx_d   = IDX_CYCLES;
          state_d = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (dump_ready) begin
          if (idx_q == IDX_IPC) begin
            idx_d   = IDX_CYCLES;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      ins_q   <= '0;
      stl_q   <= '0;
      brn_q   <= '0;
      idx_q   <= IDX_CYCLES;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      stl_q   <= stl_d;
      brn_q   <= brn_d;
      idx_q   <= idx_d;
    end
  end

  stats_divider #(
    .NUM_W (Q_W),
    .DEN_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   ({ins_d, {FRAC_W{1'b0}}}),
    .den   (cyc_d),
    .busy  (div_busy),
    .valid (div_valid),
    .quot  (div_quot)
  );

  // IPC clamps to all-ones when the quotient needs more than CNT_W bits
  assign ipc = (|div_quot[Q_W-1:CNT_W]) ? '1 : div_quot[CNT_W-1:0];

  // Dump word select, decoded from registered index and counters only
  always_comb begin
    dump_data = '0;
    case (idx_q)
      IDX_CYCLES: dump_data = cyc_q;
      IDX_INSTR:  dump_data = ins_q;
      IDX_STALL:  dump_data = stl_q;
      IDX_BRANCH: dump_data = brn_q;
      IDX_IPC:    dump_data = ipc;
      default:    dump_data = '0;
    endcase
  end

  assign dump_valid = (state_q == ST_DUMP);
  assign dump_idx   = idx_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DIV) || (state_q == ST_DUMP);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_stats_sequencer.sv
// Self-checking bench for stats_sequencer: scoreboarded dump beats, latency, priority, reset and saturation.
// Latency: n/a.
// Backpressure: dump_ready driven either constantly high or in a 0,0,1 pattern per beat.
module tb_stats_sequencer;
  import stats_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start, halt, inst_retire, stall, br_taken;
  logic        dump_valid, dump_ready;
  logic [2:0]  dump_idx;
  logic [31:0] dump_data;
  logic        busy, done;

  // Narrow instance used to reach counter saturation in a short run
  logic        s_start, s_halt, s_inst, s_stall, s_br;
  logic        s_valid, s_ready;
  logic [2:0]  s_idx;
  logic [7:0]  s_data;
  logic        s_busy, s_done;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int rdy_mode = 0;
  int ph = 0;
  logic [63:0] exp_q[$];
  logic        prev_hold = 1'b0;
  logic [2:0]  prev_idx;
  logic [31:0] prev_data;

  stats_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .inst_retire(inst_retire), .stall(stall), .br_taken(br_taken),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .busy(busy), .done(done)
  );

  stats_sequencer #(.CNT_W(8), .FRAC_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .halt(s_halt),
    .inst_retire(s_inst), .stall(s_stall), .br_taken(s_br),
    .dump_valid(s_valid), .dump_ready(s_ready), .dump_idx(s_idx),
    .dump_data(s_data), .busy(s_busy), .done(s_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] ipc_of(input logic [31:0] i, input logic [31:0] c);
    logic [39:0] n, d, q;
    n = {i, 8'h00};
    d = {8'h00, c};
    q = n / d;
    return (q[39:32] != 8'h00) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  function automatic logic [63:0] beat(input logic [2:0] idx, input logic [31:0] val);
    return {29'd0, idx, val};
  endfunction

  // Drives a run of ncyc cycles (halt on the last) and queues the expected report
  task automatic do_run(input int ncyc, input int ni, input int ns, input int nb, input bit start_at_halt);
    logic [31:0] c, i, s, b;
    for (int k = 0; k < ncyc; k++) begin
      inst_retire = (k < ni);
      stall       = (k < ns);
      br_taken    = (k < nb);
      halt        = (k == ncyc - 1);
      start       = start_at_halt && (k == ncyc - 1);
      tick();
    end
    inst_retire = 0; stall = 0; br_taken = 0; halt = 0; start = 0;
    c = 32'(ncyc); i = 32'(ni); s = 32'(ns); b = 32'(nb);
    exp_q.push_back(beat(IDX_CYCLES, c));
    exp_q.push_back(beat(IDX_INSTR, i));
    exp_q.push_back(beat(IDX_STALL, s));
    exp_q.push_back(beat(IDX_BRANCH, b));
    exp_q.push_back(beat(IDX_IPC, ipc_of(i, c)));
  endtask

  // Counts DIV cycles until the first beat; optionally pulses start mid-divide
  task automatic wait_latency(input string tag, input bit poke);
    int k = 0;
    while (!dump_valid && k < 100) begin
      start = poke && (k == 5);
      tick();
      start = 0;
      k++;
    end
    check_eq(tag, 64'(k), 64'd40);
  endtask

  task automatic wait_done(input string tag, input int hs_base);
    int k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    check_eq({tag, " done"}, 64'(done), 64'd1);
    check_eq({tag, " beats left"}, 64'(exp_q.size()), 64'd0);
    check_eq({tag, " handshakes"}, 64'(hs_cnt - hs_base), 64'd5);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " dump_valid"}, 64'(dump_valid), 64'd0);
    check_eq({tag, " busy"}, 64'(busy), 64'd0);
    check_eq({tag, " done"}, 64'(done), 64'd0);
    check_eq({tag, " dump_idx"}, 64'(dump_idx), 64'd0);
  endtask

  // Ready generator: constant high, or 0,0,1 for each beat
  initial begin
    dump_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        dump_ready = 1'b1;
      end else if (dump_valid) begin
        dump_ready = (ph == 2);
        ph = (ph == 2) ? 0 : ph + 1;
      end else begin
        dump_ready = 1'b0;
        ph = 0;
      end
    end
  end

  // Scoreboard monitor: pops on each handshake and checks stability while stalled
  initial begin
    forever begin
      @(negedge clk);
      if (dump_valid) begin
        if (prev_hold) begin
          check_eq("hold idx", 64'(dump_idx), 64'(prev_idx));
          check_eq("hold data", 64'(dump_data), 64'(prev_data));
        end
        if (dump_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) check_eq("unexpected beat", 64'(exp_q.size()), 64'd1);
          else check_eq("beat", beat(dump_idx, dump_data), exp_q.pop_front());
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_idx  = dump_idx;
          prev_data = dump_data;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int k;
    logic [7:0] s_exp [5];
    rst_n = 0; start = 0; halt = 0; inst_retire = 0; stall = 0; br_taken = 0;
    s_start = 0; s_halt = 0; s_inst = 0; s_stall = 0; s_br = 0; s_ready = 1;
    tick(2);
    check_idle_outputs("reset");
    rst_n = 1;
    tick();

    // start+halt together in IDLE: start wins, then the basic run
    start = 1; halt = 1;
    tick();
    start = 0; halt = 0;
    check_eq("idle start+halt busy", 64'(busy), 64'd1);
    check_eq("idle start+halt done", 64'(done), 64'd0);
    base = hs_cnt;
    do_run(10, 5, 3, 2, 0);
    check_eq("div busy", 64'(busy), 64'd1);
    wait_latency("latency basic", 0);
    wait_done("basic", base);

    // start in DONE, backpressured run ending with halt+start, start poked in DIV and DUMP
    start = 1;
    tick();
    start = 0;
    check_eq("restart done drop", 64'(done), 64'd0);
    check_eq("restart busy", 64'(busy), 64'd1);
    rdy_mode = 1;
    base = hs_cnt;
    do_run(10, 5, 3, 2, 1);
    wait_latency("latency backpressure", 1);
    start = 1;
    tick();
    start = 0;
    wait_done("backpressure", base);
    rdy_mode = 0;

    // IPC of exactly 1.0
    start = 1;
    tick();
    start = 0;
    base = hs_cnt;
    do_run(7, 7, 0, 0, 0);
    wait_latency("latency ipc1", 0);
    wait_done("ipc1", base);

    // Async reset in the middle of the divide
    start = 1;
    tick();
    start = 0;
    do_run(4, 2, 1, 1, 0);
    tick(10);
    #2 rst_n = 0;
    #1 check_idle_outputs("reset in div");
    exp_q.delete();
    tick();
    rst_n = 1;
    tick();
    start = 1;
    tick();
    start = 0;
    base = hs_cnt;
    do_run(6, 3, 2, 1, 0);
    wait_latency("latency after div reset", 0);
    wait_done("after div reset", base);

    // Async reset while beat 2 is on the port
    start = 1;
    tick();
    start = 0;
    do_run(8, 2, 0, 0, 0);
    k = 0;
    while (!(dump_valid && dump_idx == IDX_STALL) && k < 100) begin
      tick();
      k++;
    end
    check_eq("reached beat 2", 64'(dump_idx), 64'(IDX_STALL));
    #2 rst_n = 0;
    #1 check_idle_outputs("reset in dump");
    exp_q.delete();
    tick();
    rst_n = 1;
    tick();
    start = 1;
    tick();
    start = 0;
    base = hs_cnt;
    do_run(5, 4, 1, 3, 0);
    wait_latency("latency after dump reset", 0);
    wait_done("after dump reset", base);

    // Saturation on the 8-bit instance: 300 cycles, instr every cycle
    s_exp[0] = 8'hFF; s_exp[1] = 8'hFF; s_exp[2] = 8'd100; s_exp[3] = 8'd0; s_exp[4] = 8'hFF;
    s_start = 1;
    tick();
    s_start = 0;
    for (int c = 0; c < 300; c++) begin
      s_inst  = 1;
      s_stall = (c < 100);
      s_halt  = (c == 299);
      tick();
    end
    s_inst = 0; s_stall = 0; s_halt = 0;
    k = 0;
    while (!s_valid && k < 100) begin
      tick();
      k++;
    end
    check_eq("sat latency", 64'(k), 64'd16);
    for (int b = 0; b < NUM_BEATS; b++) begin
      check_eq("sat idx", 64'(s_idx), 64'(b));
      check_eq("sat data", 64'(s_data), 64'(s_exp[b]));
      tick();
    end
    check_eq("sat done", 64'(s_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
